// File: rtl/crc_pkg.sv
// Shared types and the single-bit CRC step used by the sequential CRC engine.
// The step works on a fixed maximum width so one function serves every CRC_WIDTH.
package crc_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } crc_state_t;

    typedef enum logic {
        CRC_GEN = 1'b0,
        CRC_CHK = 1'b1
    } crc_mode_e;

    localparam int CRC_MAX_W = 64;

    // One MSB-first LFSR step; bits at and above 'width' are cleared in the result.
    function automatic logic [CRC_MAX_W-1:0] crc_bit_step(
        input logic [CRC_MAX_W-1:0] crc,
        input logic                 d,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   width
    );
        logic                 fb;
        logic [CRC_MAX_W-1:0] mask;
        fb   = d ^ (|(crc & (64'd1 << (width - 1))));
        mask = (width >= CRC_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        return ((crc << 1) ^ (fb ? poly : '0)) & mask;
    endfunction

endpackage

// File: rtl/crc_lfsr_unroll.sv
// Combinational CRC update: applies the first n_valid of BITS_PER_CYCLE data bits
// (data_bits MSB first) to crc_in in a single cycle.
module crc_lfsr_unroll
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH      = 4,
    parameter logic [CRC_WIDTH:0]   POLY           = 5'b10011,
    parameter int                   BITS_PER_CYCLE = 1
) (
    input  logic [CRC_WIDTH-1:0]                    crc_in,
    input  logic [BITS_PER_CYCLE-1:0]               data_bits,
    input  logic [$clog2(BITS_PER_CYCLE+1)-1:0]     n_valid,
    output logic [CRC_WIDTH-1:0]                    crc_next
);

    localparam logic [CRC_MAX_W-1:0] POLY_EXT = CRC_MAX_W'(POLY[CRC_WIDTH-1:0]);

    if (CRC_WIDTH < 1 || CRC_WIDTH > CRC_MAX_W) begin : g_cw_bad
        $error("crc_lfsr_unroll: CRC_WIDTH out of range");
    end

    logic [CRC_WIDTH-1:0] acc;

    // NOTE: blocking assignments here are deliberate: each step must see the
    // previous step's result within the same evaluation to chain the bits.
    always_comb begin
        acc = crc_in;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (i < int'(n_valid)) begin
                acc = CRC_WIDTH'(crc_bit_step(CRC_MAX_W'(acc),
                                              data_bits[BITS_PER_CYCLE-1-i],
                                              POLY_EXT, CRC_WIDTH));
            end
        end
        crc_next = acc;
    end

endmodule

// File: rtl/crc_engine_seq.sv
// Sequential CRC generate/check engine with valid/ready start, abort and
// BITS_PER_CYCLE unrolling; result is registered and held until the next job.
module crc_engine_seq
    import crc_pkg::*;
#(
    parameter int                   DATA_WIDTH     = 12,
    parameter int                   CRC_WIDTH      = 4,
    parameter logic [CRC_WIDTH:0]   POLY           = 5'b10011,
    parameter logic [CRC_WIDTH-1:0] SEED           = '0,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT        = '0,
    parameter int                   BITS_PER_CYCLE = 1,
    parameter bit                   REFLECT_IN     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CRC_WIDTH-1:0]  crc_in,
    input  logic                  abort,
    output logic                  busy,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  crc_match,
    output logic                  done
);

    localparam int N_CYC = (DATA_WIDTH + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int REM   = DATA_WIDTH % BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1) + 1;
    localparam int NV_W  = $clog2(BITS_PER_CYCLE + 1);

    if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > DATA_WIDTH) begin : g_bpc_bad
        $error("crc_engine_seq: BITS_PER_CYCLE must be 1..DATA_WIDTH");
    end

    crc_state_t            state_q, state_d;
    crc_mode_e             mode_q, mode_d;
    logic [CRC_WIDTH-1:0]  crc_q, crc_d;
    logic [CRC_WIDTH-1:0]  crc_in_q, crc_in_d;
    logic [CRC_WIDTH-1:0]  crc_out_q, crc_out_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  match_q, match_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] data_rev;
    logic [NV_W-1:0]       n_steps;
    logic [CRC_WIDTH-1:0]  crc_step;
    logic [CRC_WIDTH-1:0]  crc_final;

    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++) data_rev[i] = data_in[DATA_WIDTH-1-i];
    end

    // Only the final cycle can be partial, since full chunks are consumed first.
    assign n_steps   = ((cnt_q == CNT_W'(1)) && (REM != 0)) ? NV_W'(REM) : NV_W'(BITS_PER_CYCLE);
    assign crc_final = crc_q ^ XOR_OUT;

    crc_lfsr_unroll #(
        .CRC_WIDTH      (CRC_WIDTH),
        .POLY           (POLY),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_lfsr (
        .crc_in    (crc_q),
        .data_bits (shift_q[DATA_WIDTH-1 -: BITS_PER_CYCLE]),
        .n_valid   (n_steps),
        .crc_next  (crc_step)
    );

    // NOTE: every variable gets its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        crc_d     = crc_q;
        crc_in_d  = crc_in_q;
        crc_out_d = crc_out_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    shift_d  = REFLECT_IN ? data_rev : data_in;
                    mode_d   = crc_mode_e'(mode);
                    crc_in_d = crc_in;
                    crc_d    = SEED;
                    cnt_d    = CNT_W'(N_CYC);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    crc_d   = crc_step;
                    shift_d = shift_q << n_steps;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (!abort) begin
                    crc_out_d = crc_final;
                    match_d   = (mode_q == CRC_CHK) && (crc_final == crc_in_q);
                    done_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all flops so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= CRC_GEN;
            crc_q     <= SEED;
            crc_in_q  <= '0;
            crc_out_q <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            crc_q     <= crc_d;
            crc_in_q  <= crc_in_d;
            crc_out_q <= crc_out_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            done_q    <= done_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign crc_out     = crc_out_q;
    assign crc_match   = match_q;
    assign done        = done_q;

`ifdef CRC_DEBUG
    always_ff @(posedge clk) begin
        if (done_q) $display("crc_engine_seq: done crc_out=%h match=%b", crc_out_q, match_q);
    end
`endif

endmodule
